lc3_wb_scheduler: RTL and testbench
===================================

# lc3_wb_scheduler

Register-file write-port scheduler for the LC3 writeback stage. Arbitrates the single register-file write port between the execute path (ALU/LEA results) and the memory path (LD/LDR/LDI results), and registers the winning write. Derives the NZP condition codes for the PSR and tracks a per-register pending-write mask for hazard checks by the controller. Sits between the execute/memory stages and the register file, alongside the writeback_in interface.

## Interface
Parameters:
- DATA_W, 16, register data width
- REG_AW, 3, register address width (8 registers)
- STARVE_LIMIT, 4, consecutive lost cycles after which execute overrides memory priority; legal range 1..15

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction with a destination issued this cycle
- issue_dr  in  REG_AW  destination register of issued instruction
- ex_valid  in  1  execute result available
- ex_ready  out  1  execute result accepted this cycle (combinational grant)
- ex_dr  in  REG_AW  execute destination register
- ex_data  in  DATA_W  execute result
- mem_valid  in  1  memory result available
- mem_ready  out  1  memory result accepted this cycle (combinational grant)
- mem_dr  in  REG_AW  memory destination register
- mem_data  in  DATA_W  memory result
- rf_we  out  1  register-file write enable
- rf_dr  out  REG_AW  register-file write address
- rf_data  out  DATA_W  register-file write data
- psr_we  out  1  PSR condition-code write enable
- nzp  out  3  {N,Z,P} of rf_data
- pending  out  2**REG_AW  bit i set while a write to register i is outstanding
- nonpend_err  out  1  one-cycle pulse: granted write targeted a non-pending register

## Operation
- Handshake: requester holds valid, dr, data stable until ready; a transfer occurs on a cycle with valid && ready. ready never asserts without valid; at most one of ex_ready/mem_ready is high per cycle.
- Arbitration: memory has priority. Exception: when starve counter == STARVE_LIMIT and ex_valid, execute wins.
- Starve counter (4-bit): increments on ex_valid && !ex_ready, saturates at STARVE_LIMIT; clears on ex_ready or !ex_valid.
- Write register: on a transfer, winner's dr/data load into rf_dr/rf_data and rf_we=1 next cycle. With no transfer, rf_we=0 and rf_dr/rf_data hold.
- NZP: N=rf_data[DATA_W-1]; Z=(rf_data==0); P=!N&&!Z; exactly one bit set while psr_we=1.
- Pending mask: issue_valid sets bit issue_dr; a transfer clears bit of the winner's dr at the same edge rf_we rises. Same-cycle set and clear of the same bit: set wins. Transfer to a bit already clear: write still performed; nonpend_err pulses with rf_we.
- Reset: ex_ready=mem_ready=0 while reset is high; an in-flight grant on the reset cycle is discarded.

## Timing
- Reset values: rf_we=0, rf_dr=0, rf_data=0, psr_we=0, nzp=000, pending=0, nonpend_err=0, starve counter=0.
- ready: combinational from valid inputs and starve counter, same cycle.
- Latency: transfer at edge N -> rf_we/rf_dr/rf_data/nzp valid cycle N+1, one cycle wide per transfer.
- Throughput: one write per cycle; back-to-back transfers give continuous rf_we.
- pending reflects issues/clears one cycle after the edge.
- Worst-case execute wait with continuous mem_valid: STARVE_LIMIT cycles, then granted.

## Configuration
- WB_NZP_EN defined: nzp and psr_we generated as above.
- WB_NZP_EN undefined: NZP logic removed; nzp tied 000, psr_we tied 0; all other behaviour unchanged.

## Test plan
- Reset: assert reset 2 cycles with ex_valid=mem_valid=1 -> both ready 0, all outputs at reset values, pending=0.
- Collision: ex_valid, mem_valid same cycle, mem_dr=3/mem_data=16'h8000, ex_dr=5/ex_data=16'h0001 -> mem_ready=1, next cycle rf_dr=3, nzp=100; following cycle ex wins, rf_dr=5, nzp=001.
- Starvation: mem_valid held high continuously, ex_valid high, STARVE_LIMIT=4 -> ex_ready asserts on 5th cycle exactly, counter clears.
- Zero result: lone ex transfer with ex_data=0 -> rf_we=1, nzp=010, psr_we=1 (psr_we=0, nzp=000 when WB_NZP_EN undefined).
- Pending: issue_valid dr=2, then transfer dr=2 on same cycle as new issue dr=2 -> pending[2] stays 1; later transfer dr=2 -> pending[2]=0.
- Error: transfer to dr=6 with pending[6]=0 -> rf_we=1 and nonpend_err=1 for one cycle.

Source files
------------

// File: rtl/lc3_wb_scheduler_if.sv
// Writeback scheduler bus: issue, execute/memory result handshakes and
// register-file/PSR write outputs grouped into one interface.
interface lc3_wb_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  localparam int NREG = 1 << REG_AW;

  logic              issue_valid;
  logic [REG_AW-1:0] issue_dr;

  logic              ex_valid;
  logic              ex_ready;
  logic [REG_AW-1:0] ex_dr;
  logic [DATA_W-1:0] ex_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_dr;
  logic [DATA_W-1:0] mem_data;

  logic              rf_we;
  logic [REG_AW-1:0] rf_dr;
  logic [DATA_W-1:0] rf_data;
  logic              psr_we;
  logic [2:0]        nzp;
  logic [NREG-1:0]   pending;
  logic              nonpend_err;

  modport master (
    output issue_valid, issue_dr,
    output ex_valid, ex_dr, ex_data,
    input  ex_ready,
    output mem_valid, mem_dr, mem_data,
    input  mem_ready,
    input  rf_we, rf_dr, rf_data, psr_we, nzp, pending, nonpend_err
  );

  modport slave (
    input  issue_valid, issue_dr,
    input  ex_valid, ex_dr, ex_data,
    output ex_ready,
    input  mem_valid, mem_dr, mem_data,
    output mem_ready,
    output rf_we, rf_dr, rf_data, psr_we, nzp, pending, nonpend_err
  );
endinterface

// File: rtl/lc3_wb_scheduler.sv
// LC3 writeback write-port scheduler: memory-priority arbitration with execute
// starvation override, registered RF write, pending mask. NZP/PSR under WB_NZP_EN.
module lc3_wb_scheduler #(
  parameter int DATA_W       = 16,
  parameter int REG_AW       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clock_i,
  input logic              reset_i,
  lc3_wb_scheduler_if.slave wb
);
  localparam int NREG = 1 << REG_AW;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_dr_q, rf_dr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              err_q, err_d;

  logic              ex_win, mem_win, xfer;
  logic [REG_AW-1:0] win_dr;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   set_mask, clr_mask;

  always_comb begin
    ex_win   = 1'b0;
    mem_win  = 1'b0;
    xfer     = 1'b0;
    win_dr   = '0;
    win_data = '0;
    set_mask = '0;
    clr_mask = '0;
    starve_d = starve_q;

    // Execute overrides memory only once it has waited the full limit.
    ex_win  = !reset_i && wb.ex_valid && (!wb.mem_valid || (starve_q == STARVE_MAX));
    mem_win = !reset_i && wb.mem_valid && !ex_win;
    xfer    = ex_win || mem_win;

    if (ex_win) begin
      win_dr   = wb.ex_dr;
      win_data = wb.ex_data;
    end else if (mem_win) begin
      win_dr   = wb.mem_dr;
      win_data = wb.mem_data;
    end

    if (!wb.ex_valid || ex_win)
      starve_d = '0;
    else if (starve_q < STARVE_MAX)
      starve_d = starve_q + 4'd1;

    if (wb.issue_valid)
      set_mask = NREG'(1) << wb.issue_dr;
    if (xfer)
      clr_mask = NREG'(1) << win_dr;
    pending_d = (pending_q & ~clr_mask) | set_mask;

    rf_we_d   = xfer;
    rf_dr_d   = xfer ? win_dr : rf_dr_q;
    rf_data_d = xfer ? win_data : rf_data_q;
    err_d     = xfer && !pending_q[win_dr];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_dr_q   <= '0;
      rf_data_q <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_dr_q   <= rf_dr_d;
      rf_data_q <= rf_data_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign wb.ex_ready    = ex_win;
  assign wb.mem_ready   = mem_win;
  assign wb.rf_we       = rf_we_q;
  assign wb.rf_dr       = rf_dr_q;
  assign wb.rf_data     = rf_data_q;
  assign wb.pending     = pending_q;
  assign wb.nonpend_err = err_q;

`ifdef WB_NZP_EN
  logic [2:0] nzp_q, nzp_d;
  logic       neg_bit, zero_bit;

  // Registered alongside rf_data so reset reads 000 rather than Z.
  always_comb begin
    neg_bit  = win_data[DATA_W-1];
    zero_bit = (win_data == '0);
    nzp_d    = xfer ? {neg_bit, zero_bit, !neg_bit && !zero_bit} : nzp_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) nzp_q <= 3'b000;
    else         nzp_q <= nzp_d;
  end

  assign wb.nzp    = nzp_q;
  assign wb.psr_we = rf_we_q;
`else
  assign wb.nzp    = 3'b000;
  assign wb.psr_we = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_wb_scheduler.sv
// Directed table-driven bench for lc3_wb_scheduler plus hand sequences for
// reset, starvation override and reset-cycle grant discard.
module tb_lc3_wb_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lc3_wb_scheduler_if #(.DATA_W(16), .REG_AW(3)) wb ();

  lc3_wb_scheduler #(.DATA_W(16), .REG_AW(3), .STARVE_LIMIT(4)) dut (
    .clock_i(clk),
    .reset_i(rst),
    .wb     (wb)
  );

  typedef struct {
    logic        iv;
    logic [2:0]  idr;
    logic        ev;
    logic [2:0]  edr;
    logic [15:0] edata;
    logic        mv;
    logic [2:0]  mdr;
    logic [15:0] mdata;
    logic        x_er;
    logic        x_mr;
    logic        x_we;
    logic [2:0]  x_dr;
    logic [15:0] x_data;
    logic [2:0]  x_nzp;
    logic [7:0]  x_pend;
    logic        x_err;
  } vec_t;

  vec_t vecs[12];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_nzp(input logic [2:0] n);
`ifdef WB_NZP_EN
    return n;
`else
    return 3'b000;
`endif
  endfunction

  function automatic logic exp_psr(input logic we);
`ifdef WB_NZP_EN
    return we;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic iv, input logic [2:0] idr,
                       input logic ev, input logic [2:0] edr, input logic [15:0] edata,
                       input logic mv, input logic [2:0] mdr, input logic [15:0] mdata);
    wb.issue_valid = iv;
    wb.issue_dr    = idr;
    wb.ex_valid    = ev;
    wb.ex_dr       = edr;
    wb.ex_data     = edata;
    wb.mem_valid   = mv;
    wb.mem_dr      = mdr;
    wb.mem_data    = mdata;
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [2:0] dr,
                            input logic [15:0] data, input logic [2:0] nzp,
                            input logic [7:0] pend, input logic err);
    check({tag, ".rf_we"},       32'(wb.rf_we),       32'(we));
    check({tag, ".rf_dr"},       32'(wb.rf_dr),       32'(dr));
    check({tag, ".rf_data"},     32'(wb.rf_data),     32'(data));
    check({tag, ".nzp"},         32'(wb.nzp),         32'(exp_nzp(nzp)));
    check({tag, ".psr_we"},      32'(wb.psr_we),      32'(exp_psr(we)));
    check({tag, ".pending"},     32'(wb.pending),     32'(pend));
    check({tag, ".nonpend_err"}, 32'(wb.nonpend_err), 32'(err));
  endtask

  initial begin
    //            iv idr ev edr edata     mv mdr mdata     er mr we dr data      nzp     pend   err
    vecs[0]  = '{1, 3,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b000, 8'h08, 0};
    vecs[1]  = '{1, 5,  1, 5, 16'h0001, 1, 3, 16'h8000, 0, 1, 1, 3, 16'h8000, 3'b100, 8'h20, 0};
    vecs[2]  = '{0, 0,  1, 5, 16'h0001, 0, 0, 16'h0000, 1, 0, 1, 5, 16'h0001, 3'b001, 8'h00, 0};
    vecs[3]  = '{0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 5, 16'h0001, 3'b001, 8'h00, 0};
    vecs[4]  = '{0, 0,  1, 1, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 1, 16'h0000, 3'b010, 8'h00, 1};
    vecs[5]  = '{1, 2,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 3'b010, 8'h04, 0};
    vecs[6]  = '{1, 2,  0, 0, 16'h0000, 1, 2, 16'h7fff, 0, 1, 1, 2, 16'h7fff, 3'b001, 8'h04, 0};
    vecs[7]  = '{0, 0,  1, 2, 16'hffff, 0, 0, 16'h0000, 1, 0, 1, 2, 16'hffff, 3'b100, 8'h00, 0};
    vecs[8]  = '{0, 0,  0, 0, 16'h0000, 1, 6, 16'h1234, 0, 1, 1, 6, 16'h1234, 3'b001, 8'h00, 1};
    vecs[9]  = '{0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 6, 16'h1234, 3'b001, 8'h00, 0};
    vecs[10] = '{0, 0,  1, 0, 16'h8001, 1, 7, 16'h0000, 0, 1, 1, 7, 16'h0000, 3'b010, 8'h00, 1};
    vecs[11] = '{0, 0,  1, 0, 16'h8001, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h8001, 3'b100, 8'h00, 1};

    // Reset held with both requesters valid: no grants, outputs at reset values.
    rst = 1'b1;
    drive(0, 0, 1, 5, 16'h0001, 1, 3, 16'h8000);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("reset.ex_ready",  32'(wb.ex_ready),  32'd0);
      check("reset.mem_ready", 32'(wb.mem_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 16'h0000, 3'b000, 8'h00, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].idr, vecs[i].ev, vecs[i].edr, vecs[i].edata,
            vecs[i].mv, vecs[i].mdr, vecs[i].mdata);
      #1;
      check($sformatf("v%0d.ex_ready", i),  32'(wb.ex_ready),  32'(vecs[i].x_er));
      check($sformatf("v%0d.mem_ready", i), 32'(wb.mem_ready), 32'(vecs[i].x_mr));
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), vecs[i].x_we, vecs[i].x_dr, vecs[i].x_data,
                 vecs[i].x_nzp, vecs[i].x_pend, vecs[i].x_err);
    end

    // Starvation: memory continuously valid; execute must win on cycle 5 only.
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      drive(0, 0, 1, 4, 16'h0042, 1, 1, 16'h0010);
      #1;
      check($sformatf("starve%0d.ex_ready", c),  32'(wb.ex_ready),  32'(c == 5));
      check($sformatf("starve%0d.mem_ready", c), 32'(wb.mem_ready), 32'(c != 5));
      @(posedge clk);
      #1;
      if (c == 5) begin
        check("starve.rf_dr",   32'(wb.rf_dr),   32'd4);
        check("starve.rf_data", 32'(wb.rf_data), 32'h0042);
        check("starve.nzp",     32'(wb.nzp),     32'(exp_nzp(3'b001)));
      end
    end

    // Grant presented during a reset cycle must be discarded.
    @(negedge clk);
    drive(1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000);
    @(posedge clk);
    #1;
    check("pre_rst.pending", 32'(wb.pending), 32'h08);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 3, 0, 0, 16'h0000, 1, 3, 16'h5555);
    #1;
    check("rst_grant.mem_ready", 32'(wb.mem_ready), 32'd0);
    @(posedge clk);
    #1;
    check_outs("rst_grant", 0, 0, 16'h0000, 3'b000, 8'h00, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
